// File: rtl/nrisc_fetch_pkg.sv
// Shared types and default constants for the nRisc fetch unit.
package nrisc_fetch_pkg;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    localparam int         DEFAULT_ADDR_W    = 8;
    localparam logic [7:0] DEFAULT_RESET_PC  = 8'h00;
    localparam logic [7:0] DEFAULT_PROG_LAST = 8'h07;

endpackage

// File: rtl/nrisc_fetch_unit.sv
// nRisc fetch unit: program counter and fetch sequencing in front of a
// registered (one-cycle latency) instruction bank. fetch_valid/fetch_pc are
// aligned with the bank output. Optional macro FETCH_BOUNDS_CHECK_EN halts
// with fault=1 instead of loading any next PC above PROG_LAST.
module nrisc_fetch_unit
    import nrisc_fetch_pkg::*;
#(
    parameter int                ADDR_W    = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [ADDR_W-1:0] PROG_LAST = DEFAULT_PROG_LAST
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] pc_out,
    output logic              fetch_valid,
    output logic [ADDR_W-1:0] fetch_pc,
    output logic              halted,
    output logic              fault
);

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    // Without the check every PC is in range, so fault can never be set.
    localparam bit BOUNDS_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-1){1'b0}}, 1'b1};

    fetch_state_t      state_r, state_s;
    logic [ADDR_W-1:0] pc_r, pc_s;
    logic [ADDR_W-1:0] fpc_r, fpc_s;
    logic              fv_r, fv_s;
    logic              halted_r, halted_s;
    logic              fault_r, fault_s;
    logic [ADDR_W-1:0] inc_pc_s;

    function automatic logic pc_in_range(input logic [ADDR_W-1:0] pc);
        return !BOUNDS_EN || (pc <= PROG_LAST);
    endfunction

    // Next-state, next-PC and fetch tracking; halt > redirect > stall > increment.
    always_comb begin
        state_s  = state_r;
        pc_s     = pc_r;
        fpc_s    = fpc_r;
        fv_s     = fv_r;
        halted_s = halted_r;
        fault_s  = fault_r;
        inc_pc_s = pc_r + PC_STEP;
        case (state_r)
            IDLE: begin
                fv_s = 1'b0;
                if (enable) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN, STALL: begin
                if (halt_req) begin
                    state_s  = HALT;
                    fv_s     = 1'b0;
                    halted_s = 1'b1;
                end else if (redirect_valid) begin
                    if (pc_in_range(redirect_target)) begin
                        // Squash the sequential word the bank captures now.
                        state_s = RUN;
                        pc_s    = redirect_target;
                        fv_s    = 1'b0;
                    end else begin
                        state_s  = HALT;
                        fv_s     = 1'b0;
                        halted_s = 1'b1;
                        fault_s  = 1'b1;
                    end
                end else if (stall) begin
                    // Bank re-reads the same address, so everything holds.
                    state_s = STALL;
                end else begin
                    if (pc_in_range(inc_pc_s)) begin
                        state_s = RUN;
                        pc_s    = inc_pc_s;
                        fpc_s   = pc_r;
                        fv_s    = 1'b1;
                    end else begin
                        state_s  = HALT;
                        fv_s     = 1'b0;
                        halted_s = 1'b1;
                        fault_s  = 1'b1;
                    end
                end
            end
            HALT: begin
                fv_s     = 1'b0;
                halted_s = 1'b1;
            end
            default: begin
                state_s = IDLE;
                fv_s    = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset forces a clean IDLE at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            pc_r     <= RESET_PC;
            fpc_r    <= RESET_PC;
            fv_r     <= 1'b0;
            halted_r <= 1'b0;
            fault_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            fpc_r    <= fpc_s;
            fv_r     <= fv_s;
            halted_r <= halted_s;
            fault_r  <= fault_s;
        end
    end

    assign pc_out      = pc_r;
    assign fetch_valid = fv_r;
    assign fetch_pc    = fpc_r;
    assign halted      = halted_r;
    assign fault       = fault_r;

endmodule

// File: tb/tb_nrisc_fetch_unit.sv
// Self-checking bench for nrisc_fetch_unit: directed scenarios plus random
// stimulus against a transaction-level reference model.
module tb_nrisc_fetch_unit;

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif
    localparam int PROG_LAST = 7;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       stall = 1'b0;
    logic       redirect_valid = 1'b0;
    logic [7:0] redirect_target = 8'h00;
    logic       halt_req = 1'b0;
    logic [7:0] pc_out;
    logic       fetch_valid;
    logic [7:0] fetch_pc;
    logic       halted;
    logic       fault;

    logic [18:0] dut_vec;
    logic [18:0] exp;
    int n_cmp = 0;
    int n_err = 0;

    // Reference model: has the unit been started, has it stopped, and what
    // word is on the bank output.
    bit         m_started, m_halted, m_fault, m_fv;
    logic [7:0] m_pc, m_fpc;

    nrisc_fetch_unit dut (
        .clock(clock), .reset(reset), .enable(enable), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .halt_req(halt_req), .pc_out(pc_out), .fetch_valid(fetch_valid),
        .fetch_pc(fetch_pc), .halted(halted), .fault(fault)
    );

    always #5 clock = ~clock;

    assign dut_vec = {pc_out, fetch_valid, fetch_pc, halted, fault};

    function automatic logic [18:0] pack(input logic [7:0] pc, input logic fv,
                                         input logic [7:0] fpc, input logic h, input logic f);
        return {pc, fv, fpc, h, f};
    endfunction

    function automatic logic [18:0] model_vec();
        return {m_pc, m_fv, m_fpc, m_halted, m_fault};
    endfunction

    function automatic void model_reset();
        m_started = 1'b0; m_halted = 1'b0; m_fault = 1'b0; m_fv = 1'b0;
        m_pc = 8'h00; m_fpc = 8'h00;
    endfunction

    function automatic void model_stop(input bit with_fault);
        m_halted = 1'b1; m_fv = 1'b0;
        if (with_fault) m_fault = 1'b1;
    endfunction

    function automatic void model_step(input logic en, input logic st, input logic rv,
                                       input logic [7:0] rt, input logic hr);
        int nxt;
        nxt = (int'(m_pc) + 1) % 256;
        if (m_halted) m_fv = 1'b0;
        else if (!m_started) begin
            m_fv = 1'b0;
            if (en) m_started = 1'b1;
        end else if (hr) model_stop(1'b0);
        else if (rv) begin
            if (BOUNDS && int'(rt) > PROG_LAST) model_stop(1'b1);
            else begin m_pc = rt; m_fv = 1'b0; end
        end else if (!st) begin
            if (BOUNDS && nxt > PROG_LAST) model_stop(1'b1);
            else begin m_fpc = m_pc; m_pc = 8'(nxt); m_fv = 1'b1; end
        end
    endfunction

    task automatic drive(input logic en, input logic st, input logic rv,
                         input logic [7:0] rt, input logic hr);
        enable = en; stall = st; redirect_valid = rv; redirect_target = rt; halt_req = hr;
        model_step(en, st, rv, rt, hr);
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        enable = 1'b0; stall = 1'b0; redirect_valid = 1'b0; halt_req = 1'b0;
        reset = 1'b1;
        model_reset();
        #2;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        enable = 1'b0; stall = 1'b0; redirect_valid = 1'b0; halt_req = 1'b0;
        reset = 1'b1;
        model_reset();
        #7;
        n_cmp++;
        if (dut_vec !== pack(8'h00, 1'b0, 8'h00, 1'b0, 1'b0)) begin
            n_err++; $display("FAIL reset_values: got %h expected %h", dut_vec, pack(8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, 8'h33, 1'b0);
            n_cmp++;
            if (dut_vec !== pack(8'h00, 1'b0, 8'h00, 1'b0, 1'b0)) begin
                n_err++; $display("FAIL idle_hold%0d: got %h expected %h", i, dut_vec, pack(8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
            end
        end
    endtask

    task automatic test_sequential();
        apply_reset();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (dut_vec !== pack(8'h00, 1'b0, 8'h00, 1'b0, 1'b0)) begin
            n_err++; $display("FAIL run_entry: got %h expected %h", dut_vec, pack(8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
        end
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
            exp = pack(8'(i), 1'b1, 8'(i - 1), 1'b0, 1'b0);
            n_cmp++;
            if (dut_vec !== exp) begin
                n_err++; $display("FAIL seq_step%0d: got %h expected %h", i, dut_vec, exp);
            end
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 8'h05, 1'b0);
        n_cmp++;
        if ({pc_out, fetch_valid, halted} !== {8'h05, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL redirect_squash: got pc=%h fv=%b expected pc=05 fv=0", pc_out, fetch_valid);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (dut_vec !== pack(8'h06, 1'b1, 8'h05, 1'b0, 1'b0)) begin
            n_err++; $display("FAIL redirect_target_valid: got %h expected %h", dut_vec, pack(8'h06, 1'b1, 8'h05, 1'b0, 1'b0));
        end
    endtask

    task automatic test_stall();
        apply_reset();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            n_cmp++;
            if (dut_vec !== pack(8'h03, 1'b1, 8'h02, 1'b0, 1'b0)) begin
                n_err++; $display("FAIL stall_hold%0d: got %h expected %h", i, dut_vec, pack(8'h03, 1'b1, 8'h02, 1'b0, 1'b0));
            end
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (dut_vec !== pack(8'h04, 1'b1, 8'h03, 1'b0, 1'b0)) begin
            n_err++; $display("FAIL stall_release: got %h expected %h", dut_vec, pack(8'h04, 1'b1, 8'h03, 1'b0, 1'b0));
        end
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 8'h01, 1'b0);
        n_cmp++;
        if ({pc_out, fetch_valid} !== {8'h01, 1'b0}) begin
            n_err++; $display("FAIL stall_redirect: got pc=%h fv=%b expected pc=01 fv=0", pc_out, fetch_valid);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (dut_vec !== pack(8'h02, 1'b1, 8'h01, 1'b0, 1'b0)) begin
            n_err++; $display("FAIL stall_redirect_resume: got %h expected %h", dut_vec, pack(8'h02, 1'b1, 8'h01, 1'b0, 1'b0));
        end
    endtask

    task automatic test_halt();
        apply_reset();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 8'h06, 1'b1);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({pc_out, fetch_valid, halted, fault} !== {8'h01, 1'b0, 1'b1, 1'b0}) begin
                n_err++; $display("FAIL halt_absorb%0d: got pc=%h fv=%b halted=%b fault=%b expected pc=01 fv=0 halted=1 fault=0",
                                  i, pc_out, fetch_valid, halted, fault);
            end
            drive(1'b1, 1'($urandom_range(0, 1)), 1'b1, 8'($urandom_range(0, 7)), 1'b0);
        end
        apply_reset();
        n_cmp++;
        if ({pc_out, halted, fetch_valid} !== {8'h00, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL halt_reset: got pc=%h halted=%b fv=%b expected pc=00 halted=0 fv=0", pc_out, halted, fetch_valid);
        end
    endtask

`ifdef FETCH_BOUNDS_CHECK_EN
    task automatic test_bounds();
        apply_reset();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (dut_vec !== pack(8'h07, 1'b1, 8'h06, 1'b0, 1'b0)) begin
            n_err++; $display("FAIL bounds_last: got %h expected %h", dut_vec, pack(8'h07, 1'b1, 8'h06, 1'b0, 1'b0));
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
            n_cmp++;
            if ({pc_out, fetch_valid, halted, fault} !== {8'h07, 1'b0, 1'b1, 1'b1}) begin
                n_err++; $display("FAIL bounds_fault%0d: got pc=%h fv=%b halted=%b fault=%b expected pc=07 fv=0 halted=1 fault=1",
                                  i, pc_out, fetch_valid, halted, fault);
            end
        end
        apply_reset();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 8'h08, 1'b0);
        n_cmp++;
        if ({pc_out, fetch_valid, halted, fault} !== {8'h00, 1'b0, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL bounds_redirect: got pc=%h fv=%b halted=%b fault=%b expected pc=00 fv=0 halted=1 fault=1",
                              pc_out, fetch_valid, halted, fault);
        end
    endtask
`else
    task automatic test_wrap();
        apply_reset();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 8'hFE, 1'b0);
        n_cmp++;
        if ({pc_out, fetch_valid} !== {8'hFE, 1'b0}) begin
            n_err++; $display("FAIL wrap_preload: got pc=%h fv=%b expected pc=fe fv=0", pc_out, fetch_valid);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (dut_vec !== pack(8'hFF, 1'b1, 8'hFE, 1'b0, 1'b0)) begin
            n_err++; $display("FAIL wrap_ff: got %h expected %h", dut_vec, pack(8'hFF, 1'b1, 8'hFE, 1'b0, 1'b0));
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (dut_vec !== pack(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0)) begin
            n_err++; $display("FAIL wrap_00: got %h expected %h", dut_vec, pack(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0));
        end
    endtask
`endif

    task automatic test_async_reset();
        apply_reset();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < (BOUNDS ? 8 : 3); i++) drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (dut_vec !== model_vec()) begin
            n_err++; $display("FAIL async_pre: got %h expected %h", dut_vec, model_vec());
        end
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (dut_vec !== pack(8'h00, 1'b0, 8'h00, 1'b0, 1'b0)) begin
            n_err++; $display("FAIL async_clear: got %h expected %h", dut_vec, pack(8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
        end
        @(negedge clock);
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (dut_vec !== pack(8'h01, 1'b1, 8'h00, 1'b0, 1'b0)) begin
            n_err++; $display("FAIL async_restart: got %h expected %h", dut_vec, pack(8'h01, 1'b1, 8'h00, 1'b0, 1'b0));
        end
    endtask

    task automatic test_random();
        logic [7:0] rt;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0 || (m_halted && $urandom_range(0, 7) == 0)) apply_reset();
            rt = BOUNDS ? 8'($urandom_range(0, 9)) : 8'($urandom_range(0, 255));
            drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 5) == 0), rt, 1'($urandom_range(0, 49) == 0));
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_err++; $display("FAIL random_cycle%0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sequential();
        test_redirect();
        test_stall();
        test_halt();
`ifdef FETCH_BOUNDS_CHECK_EN
        test_bounds();
`else
        test_wrap();
`endif
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
